tiny_dnn_out_ctl: RTL and testbench
===================================

TINY_DNN_OUT_CTL -- requirements
Module: tiny_dnn_out_ctl

Interface
REQ-001 SHALL have parameter ACC_W, default 32, accumulator result width.
REQ-002 SHALL have parameter OUT_W, default 16, stored output width.
REQ-003 SHALL have parameter FRAC, default 8, fixed-point right-shift applied before storing.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 s_init  input  1  layer-start pulse; clears counters and buffer.
REQ-007 backprop  input  1  level; when 1, bias and activation are bypassed.
REQ-008 k_fin  input  1  one-cycle pulse; acc holds a finished output pixel.
REQ-009 acc  input  ACC_W  signed accumulator result, sampled when k_fin=1.
REQ-010 dd, oh, ow  input  4/5/5  inclusive last index of channel, row and column loops.
REQ-011 os  input  10  output plane stride in words.
REQ-012 out_stall  input  1  output memory port unavailable this cycle.
REQ-013 bias  input  OUT_W  signed bias; read data for ba, valid 1 cycle after ba.
REQ-014 out_busy  output  1  buffer full; the kernel sequencer holds its next kernel start.
REQ-015 outr  output  1  layer outputs still pending write.
REQ-016 ba  output  4  bias read address (current output channel).
REQ-017 oa  output  12  output write address.
REQ-018 owe  output  1  output write enable.
REQ-019 odata  output  OUT_W  output write data.

Function
REQ-020 SHALL buffer k_fin results in a 2-entry FIFO.
REQ-021 out_busy SHALL equal (count==2), registered.
REQ-022 A k_fin arriving while the FIFO is full SHALL be dropped and SHALL set sticky status bit ovf, cleared by s_init.
REQ-023 Pop SHALL occur when the FIFO is non-empty, out_stall=0 and the pipeline is not stalled; simultaneous push and pop SHALL keep count unchanged.
REQ-024 Pipeline stages: P0 pop and drive ba=dc; P1 sum=acc+(bias<<<FRAC), or sum=acc if backprop; P2 owe=1, odata=sat(sum>>>FRAC).
REQ-025 Latency from k_fin to owe SHALL be 3 cycles with an empty FIFO and out_stall=0.
REQ-026 out_stall=1 SHALL freeze P0-P2 and force owe=0, with no data loss.
REQ-027 sat SHALL clamp to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-028 Output counters SHALL advance per write in the order ox 0..ow, then oy 0..oh, then dc 0..dd, with ox innermost.
REQ-029 oa SHALL equal dc*os + oy*(ow+1) + ox, truncated to 12 bits.
REQ-030 outr SHALL set on s_init and clear in the cycle after the write with dc=dd, oy=oh, ox=ow.
REQ-031 A k_fin in the same cycle as s_init SHALL be accepted into the freshly cleared FIFO.
REQ-032 s_init mid-layer SHALL discard FIFO and pipeline contents (owe=0 next cycle) and zero all counters.
REQ-033 k_fin pulses after the final write of a layer SHALL be ignored until the next s_init.

Reset
REQ-034 On rst=0: out_busy=0, outr=0, owe=0, oa=0, ba=0, odata=0; FIFO empty; counters 0; ovf=0.
REQ-035 Release of rst SHALL take effect at the next clock edge; no output pulses SHALL occur at release.

Configuration
REQ-036 Macro TINY_DNN_OUT_RELU_EN: when defined and backprop=0, P2 SHALL force negative results to 0 after saturation; when undefined, or when backprop=1, there SHALL be no activation.

Structure
REQ-037 Shared package tiny_dnn_pkg SHALL hold ACC_W/OUT_W/FRAC defaults, the dimension field widths (4/5/10/12) and the sat function.
REQ-038 The three output counters SHALL be instances of the existing loop1 sub-module; the FIFO and pipeline SHALL be inline.

Verification
REQ-039 dd=0, oh=1, ow=1, os=4, bias=0, acc=256,512,768,1024 -> owe at oa 0,1,2,3 with odata 1,2,3,4; outr falls after 4th write.
REQ-040 Three back-to-back k_fin with out_stall=1 -> out_busy=1 after two; third dropped, ovf=1; release stall -> two writes.
REQ-041 acc=0x7FFFFFFF, bias=0x7FFF -> odata=0x7FFF; acc=-2^31 -> odata=0x8000, or 0 with RELU_EN.
REQ-042 backprop=1, bias=100, acc=-512 -> odata=-2 (0xFFFE) regardless of RELU_EN.
REQ-043 dd=1, oh=0, ow=0, os=9 -> writes at oa 0 then 9, with ba 0 then 1.
REQ-044 s_init while FIFO holds 2 entries -> no owe next cycle, out_busy=0, counters 0; rst=0 mid-write -> all outputs 0 immediately.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared defaults, loop-dimension field widths and the saturation helper used by the
// tiny DNN output path.
package tiny_dnn_pkg;
   localparam int ACC_W_DEF = 32;
   localparam int OUT_W_DEF = 16;
   localparam int FRAC_DEF  = 8;
   localparam int DC_W      = 4;
   localparam int PIX_W     = 5;
   localparam int OS_W      = 10;
   localparam int OA_W      = 12;
   localparam int SAT_W     = 64;

   // Clamp a sign-extended value into the signed range of a w-bit result.
   function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                   input int w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) return hi;
      else if (x < lo) return lo;
      else return x;
   endfunction
endpackage

// File: rtl/tiny_dnn_out_ctl_loop1.sv
// loop1: one level of a nested loop counter; counts 0..last and reports wrap at the last index.
module loop1
   import tiny_dnn_pkg::*;
#(
   parameter int W = PIX_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] cnt,
   output logic         wrap
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // >= keeps the counter bounded if the limit shrinks mid-layer
   assign wrap = (cnt_q >= last);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) cnt_d = '0;
      else if (en) cnt_d = wrap ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/tiny_dnn_out_ctl.sv
// Output controller: buffers finished pixels, adds bias, rescales/saturates and writes them out.
// Optional ReLU on the forward path is enabled by defining TINY_DNN_OUT_RELU_EN.
module tiny_dnn_out_ctl
   import tiny_dnn_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int FRAC  = FRAC_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_init,
   input  logic                    backprop,
   input  logic                    k_fin,
   input  logic signed [ACC_W-1:0] acc,
   input  logic [DC_W-1:0]         dd,
   input  logic [PIX_W-1:0]        oh,
   input  logic [PIX_W-1:0]        ow,
   input  logic [OS_W-1:0]         os,
   input  logic                    out_stall,
   input  logic signed [OUT_W-1:0] bias,
   output logic                    out_busy,
   output logic                    outr,
   output logic [DC_W-1:0]         ba,
   output logic [OA_W-1:0]         oa,
   output logic                    owe,
   output logic [OUT_W-1:0]        odata,
   output logic                    ovf
);
   localparam int SUM_W = ((ACC_W > OUT_W + FRAC) ? ACC_W : OUT_W + FRAC) + 1;

   // Handshake: k_fin is a one-cycle push accepted unless out_busy (count==2) is high, in
   // which case it is dropped and ovf latches; the write port consumes a word whenever
   // owe=1, and out_stall=1 freezes every stage and holds owe low.
   logic signed [ACC_W-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d, head;
   logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]              count_q, count_d;
   logic                    full, push, pop, drop, final_wr, last_iss;

   logic                    p1_vld_q, p1_vld_d, p1_new_q, p1_new_d, p1_last_q, p1_last_d;
   logic signed [ACC_W-1:0] p1_acc_q, p1_acc_d;
   logic signed [OUT_W-1:0] p1_bias_q, p1_bias_d, bias_eff;
   logic [OA_W-1:0]         p1_oa_q, p1_oa_d, oa_iss;

   logic                    p2_vld_q, p2_vld_d, p2_last_q, p2_last_d;
   logic [OA_W-1:0]         p2_oa_q, p2_oa_d;
   logic [OUT_W-1:0]        p2_data_q, p2_data_d, res;

   logic signed [SUM_W-1:0] acc_x, bias_x, sum, shifted;
   logic signed [SAT_W-1:0] wide;

   logic                    outr_q, outr_d, done_q, done_d, ovf_q, ovf_d;
   logic                    out_busy_q, out_busy_d;

   logic [DC_W-1:0]         dc_cnt;
   logic [PIX_W-1:0]        oy_cnt, ox_cnt;
   logic                    dc_wrap, oy_wrap, ox_wrap;

   // Counters step at pop; pops retire in order, so the sequence matches the write order.
   loop1 #(.W(PIX_W)) u_ox (
      .clk(clk), .rst(rst), .clr(s_init), .en(pop),
      .last(ow), .cnt(ox_cnt), .wrap(ox_wrap)
   );
   loop1 #(.W(PIX_W)) u_oy (
      .clk(clk), .rst(rst), .clr(s_init), .en(pop & ox_wrap),
      .last(oh), .cnt(oy_cnt), .wrap(oy_wrap)
   );
   loop1 #(.W(DC_W)) u_dc (
      .clk(clk), .rst(rst), .clr(s_init), .en(pop & ox_wrap & oy_wrap),
      .last(dd), .cnt(dc_cnt), .wrap(dc_wrap)
   );

   assign full     = (count_q == 2'd2);
   assign head     = rd_ptr_q ? fifo1_q : fifo0_q;
   assign owe      = p2_vld_q & ~out_stall;
   assign final_wr = owe & p2_last_q;
   assign last_iss = ox_wrap & oy_wrap & dc_wrap;
   assign pop      = (count_q != 2'd0) & ~out_stall & ~done_q & ~s_init;
   assign push     = k_fin & outr_q & ~full & ~final_wr;
   assign drop     = k_fin & outr_q & full;
   assign oa_iss   = OA_W'(dc_cnt) * OA_W'(os) + OA_W'(oy_cnt) * (OA_W'(ow) + 1'b1)
                     + OA_W'(ox_cnt);

   always_comb begin
      fifo0_d  = fifo0_q;
      fifo1_d  = fifo1_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (s_init) begin
         // a k_fin coincident with s_init lands in the freshly cleared buffer
         rd_ptr_d = 1'b0;
         wr_ptr_d = k_fin;
         count_d  = {1'b0, k_fin};
         if (k_fin) fifo0_d = acc;
      end else if (final_wr) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            if (wr_ptr_q) fifo1_d = acc;
            else fifo0_d = acc;
            wr_ptr_d = ~wr_ptr_q;
         end
         if (pop) rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_comb begin
      // bias answers the address of the previous cycle; keep it if P1 is held by a stall
      bias_eff  = p1_new_q ? bias : p1_bias_q;
      p1_bias_d = bias_eff;
      p1_new_d  = pop;
      acc_x     = {{(SUM_W-ACC_W){p1_acc_q[ACC_W-1]}}, p1_acc_q};
      bias_x    = {{(SUM_W-OUT_W){bias_eff[OUT_W-1]}}, bias_eff};
      sum       = backprop ? acc_x : acc_x + (bias_x <<< FRAC);
      shifted   = sum >>> FRAC;
      wide      = {{(SAT_W-SUM_W){shifted[SUM_W-1]}}, shifted};
      res       = OUT_W'(sat(wide, OUT_W));
`ifdef TINY_DNN_OUT_RELU_EN
      if (!backprop && res[OUT_W-1]) res = '0;
`endif
      p1_vld_d  = p1_vld_q;
      p1_acc_d  = p1_acc_q;
      p1_oa_d   = p1_oa_q;
      p1_last_d = p1_last_q;
      p2_vld_d  = p2_vld_q;
      p2_oa_d   = p2_oa_q;
      p2_last_d = p2_last_q;
      p2_data_d = p2_data_q;
      if (s_init) begin
         p1_vld_d = 1'b0;
         p2_vld_d = 1'b0;
      end else if (!out_stall) begin
         p1_vld_d = pop;
         if (pop) begin
            p1_acc_d  = head;
            p1_oa_d   = oa_iss;
            p1_last_d = last_iss;
         end
         p2_vld_d = p1_vld_q;
         if (p1_vld_q) begin
            p2_oa_d   = p1_oa_q;
            p2_last_d = p1_last_q;
            p2_data_d = res;
         end
      end
   end

   always_comb begin
      outr_d     = s_init ? 1'b1 : (final_wr ? 1'b0 : outr_q);
      done_d     = s_init ? 1'b0 : (done_q | (pop & last_iss));
      ovf_d      = s_init ? 1'b0 : (ovf_q | drop);
      out_busy_d = (count_d == 2'd2);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fifo0_q    <= '0;
         fifo1_q    <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
         p1_vld_q   <= 1'b0;
         p1_new_q   <= 1'b0;
         p1_last_q  <= 1'b0;
         p1_acc_q   <= '0;
         p1_bias_q  <= '0;
         p1_oa_q    <= '0;
         p2_vld_q   <= 1'b0;
         p2_last_q  <= 1'b0;
         p2_oa_q    <= '0;
         p2_data_q  <= '0;
         outr_q     <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         out_busy_q <= 1'b0;
      end else begin
         fifo0_q    <= fifo0_d;
         fifo1_q    <= fifo1_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         p1_vld_q   <= p1_vld_d;
         p1_new_q   <= p1_new_d;
         p1_last_q  <= p1_last_d;
         p1_acc_q   <= p1_acc_d;
         p1_bias_q  <= p1_bias_d;
         p1_oa_q    <= p1_oa_d;
         p2_vld_q   <= p2_vld_d;
         p2_last_q  <= p2_last_d;
         p2_oa_q    <= p2_oa_d;
         p2_data_q  <= p2_data_d;
         outr_q     <= outr_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         out_busy_q <= out_busy_d;
      end
   end

   assign out_busy = out_busy_q;
   assign outr     = outr_q;
   assign ba       = dc_cnt;
   assign oa       = p2_oa_q;
   assign odata    = p2_data_q;
   assign ovf      = ovf_q;
endmodule

// File: tb/tb_tiny_dnn_out_ctl.sv
// Directed bench for tiny_dnn_out_ctl: single-pixel vector table plus multi-cycle sequences.
module tb_tiny_dnn_out_ctl;
   logic        clk = 1'b0;
   logic        rst;
   logic        s_init, backprop, k_fin, out_stall;
   logic [31:0] acc;
   logic [3:0]  dd;
   logic [4:0]  oh, ow;
   logic [9:0]  os;
   logic [15:0] bias = 16'h0000;
   logic        out_busy, outr, owe, ovf;
   logic [3:0]  ba;
   logic [11:0] oa;
   logic [15:0] odata;

   logic [15:0] bias_tbl [16];
   logic [27:0] exp_q [$];
   logic [27:0] exp_w;
   int          n_cmp = 0;
   int          n_err = 0;
   int          wr_cnt = 0;
   int          base;

   typedef struct {
      logic [31:0] acc;
      logic [15:0] bias;
      logic        bp;
      logic [15:0] exp;
   } vec_t;
   vec_t vt [12];

   tiny_dnn_out_ctl dut (
      .clk(clk), .rst(rst), .s_init(s_init), .backprop(backprop), .k_fin(k_fin),
      .acc(acc), .dd(dd), .oh(oh), .ow(ow), .os(os), .out_stall(out_stall), .bias(bias),
      .out_busy(out_busy), .outr(outr), .ba(ba), .oa(oa), .owe(owe), .odata(odata),
      .ovf(ovf)
   );

   always #5 clk = ~clk;

   // bias memory: data for address ba appears one cycle later
   always @(posedge clk) bias <= bias_tbl[ba];

   // write-port scoreboard
   always @(posedge clk) begin
      if (rst && owe) begin
         wr_cnt++;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got oa=%0d odata=%h, required no write", oa, odata);
         end else begin
            exp_w = exp_q.pop_front();
            if ({oa, odata} !== exp_w) begin
               n_err++;
               $display("FAIL write: got oa=%0d odata=%h, required oa=%0d odata=%h",
                        oa, odata, exp_w[27:16], exp_w[15:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic wait_writes(input int target, input int budget);
      int cyc;
      cyc = 0;
      while (wr_cnt < target && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      #1;
      chk("write_count", wr_cnt, target);
   endtask

   function automatic logic [15:0] act_exp(input logic [15:0] v, input logic bp);
      logic relu_on;
      relu_on = 1'b0;
`ifdef TINY_DNN_OUT_RELU_EN
      relu_on = 1'b1;
`endif
      if (relu_on && !bp && v[15]) return 16'h0000;
      return v;
   endfunction

   initial begin
      vt[0]  = '{32'd1280,     16'h0003, 1'b0, 16'h0008};
      vt[1]  = '{32'h7FFFFFFF, 16'h7FFF, 1'b0, 16'h7FFF};
      vt[2]  = '{32'h80000000, 16'h0000, 1'b0, 16'h8000};
      vt[3]  = '{32'hFFFFFE00, 16'h0064, 1'b1, 16'hFFFE};
      vt[4]  = '{32'hFFFFFE00, 16'h0001, 1'b0, 16'hFFFF};
      vt[5]  = '{32'h00000064, 16'h0000, 1'b0, 16'h0000};
      vt[6]  = '{32'hFFFFFFFF, 16'h0000, 1'b0, 16'hFFFF};
      vt[7]  = '{32'h007FFFFF, 16'h0000, 1'b0, 16'h7FFF};
      vt[8]  = '{32'h00800000, 16'h0000, 1'b0, 16'h7FFF};
      vt[9]  = '{32'h00000000, 16'hFFFB, 1'b1, 16'h0000};
      vt[10] = '{32'h00000000, 16'hFFFB, 1'b0, 16'hFFFB};
      vt[11] = '{32'hFF7FFFFF, 16'h0000, 1'b0, 16'h8000};
      for (int i = 0; i < 16; i++) bias_tbl[i] = 16'h0000;

      // clock/reset
      rst = 1'b1; s_init = 0; backprop = 0; k_fin = 0; out_stall = 0; acc = 0;
      dd = 0; oh = 0; ow = 0; os = 0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_busy", out_busy, 0);
      chk("rst_outr", outr, 0);
      chk("rst_owe", owe, 0);
      chk("rst_oa", oa, 0);
      chk("rst_ba", ba, 0);
      chk("rst_odata", odata, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("post_rst_owe", owe, 0);
      chk("post_rst_outr", outr, 0);

      // single-pixel vectors: k_fin with s_init, owe three cycles later
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         dd = 0; oh = 0; ow = 0; os = 0;
         bias_tbl[0] = vt[i].bias; backprop = vt[i].bp; acc = vt[i].acc;
         s_init = 1; k_fin = 1;
         exp_q.push_back({12'd0, act_exp(vt[i].exp, vt[i].bp)});
         @(negedge clk); s_init = 0; k_fin = 0; #1 chk("lat_c1_owe", owe, 0);
         @(negedge clk); #1 chk("lat_c2_owe", owe, 0);
         @(negedge clk); #1 chk("lat_c3_owe", owe, 1); chk("outr_during", outr, 1);
         @(negedge clk); #1 chk("outr_after", outr, 0);
      end
      backprop = 0;

      // pulses after the final write are ignored
      base = wr_cnt;
      @(negedge clk); k_fin = 1; acc = 32'd2560;
      @(negedge clk); k_fin = 0;
      repeat (6) @(negedge clk);
      #1 chk("late_kfin_writes", wr_cnt, base);
      chk("late_kfin_outr", outr, 0);

      // 2x2 plane, back-to-back results
      base = wr_cnt;
      bias_tbl[0] = 0;
      @(negedge clk); dd = 0; oh = 1; ow = 1; os = 4; s_init = 1; k_fin = 1; acc = 256;
      for (int i = 1; i <= 4; i++) exp_q.push_back({12'(i - 1), 16'(i)});
      @(negedge clk); s_init = 0; acc = 512;
      @(negedge clk); acc = 768;
      @(negedge clk); acc = 1024;
      @(negedge clk); k_fin = 0; #1 chk("plane_outr_mid", outr, 1);
      chk("plane_busy", out_busy, 0);
      wait_writes(base + 4, 20);
      chk("plane_outr_end", outr, 0);

      // two channels, one pixel each, stride 9
      base = wr_cnt;
      bias_tbl[0] = 16'h0000; bias_tbl[1] = 16'h0001;
      @(negedge clk); dd = 1; oh = 0; ow = 0; os = 9; s_init = 1; k_fin = 1; acc = 512;
      exp_q.push_back({12'd0, 16'd2});
      exp_q.push_back({12'd9, 16'd3});
      @(negedge clk); s_init = 0; #1 chk("ch_ba0", ba, 0);
      @(negedge clk); k_fin = 0; #1 chk("ch_ba1", ba, 1);
      wait_writes(base + 2, 20);
      chk("ch_outr_end", outr, 0);

      // overflow under stall, then stalled pipeline drains without loss
      base = wr_cnt;
      bias_tbl[0] = 0; bias_tbl[1] = 0;
      @(negedge clk); dd = 0; oh = 0; ow = 3; os = 0; out_stall = 1;
      s_init = 1; k_fin = 1; acc = 32'd2560;
      @(negedge clk); s_init = 0; acc = 32'd2816; #1 chk("ovf_busy1", out_busy, 0);
      @(negedge clk); acc = 32'd3072; #1 chk("ovf_busy2", out_busy, 1);
      chk("ovf_before", ovf, 0);
      @(negedge clk); k_fin = 0; #1 chk("ovf_set", ovf, 1);
      chk("ovf_stall_owe", owe, 0);
      exp_q.push_back({12'd0, 16'd10});
      exp_q.push_back({12'd1, 16'd11});
      @(negedge clk); out_stall = 0;
      wait_writes(base + 2, 20);
      chk("ovf_drained_busy", out_busy, 0);
      exp_q.push_back({12'd2, 16'd20});
      exp_q.push_back({12'd3, 16'd21});
      begin
         logic [11:0] pat;
         pat = 12'b1011_0100_1101;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            out_stall = pat[i];
            k_fin = (i < 2);
            acc = (i == 0) ? 32'd5120 : 32'd5376;
            #1 if (out_stall) chk("stall_owe", owe, 0);
         end
      end
      @(negedge clk); k_fin = 0; out_stall = 0;
      wait_writes(base + 4, 20);
      chk("stall_outr_end", outr, 0);
      chk("ovf_sticky", ovf, 1);

      // s_init while the buffer is full
      base = wr_cnt;
      @(negedge clk); dd = 1; oh = 0; ow = 0; os = 5; s_init = 1; k_fin = 1; acc = 256;
      exp_q.push_back({12'd0, 16'd1});
      @(negedge clk); s_init = 0; k_fin = 0; #1 chk("sinit_ovf_clr", ovf, 0);
      wait_writes(base + 1, 10);
      chk("sinit_ba_adv", ba, 1);
      @(negedge clk); out_stall = 1; k_fin = 1; acc = 512;
      @(negedge clk);
      @(negedge clk); k_fin = 0; #1 chk("sinit_busy_pre", out_busy, 1);
      @(negedge clk); out_stall = 0; s_init = 1;
      @(negedge clk); s_init = 0; #1 chk("sinit_owe", owe, 0);
      chk("sinit_busy", out_busy, 0);
      chk("sinit_ba", ba, 0);
      chk("sinit_outr", outr, 1);
      repeat (5) @(negedge clk);
      #1 chk("sinit_no_writes", wr_cnt, base + 1);

      // asynchronous reset while a write is on the port
      base = wr_cnt;
      @(negedge clk); dd = 0; oh = 0; ow = 1; os = 0; s_init = 1; k_fin = 1; acc = 32'd1792;
      exp_q.push_back({12'd0, 16'd7});
      @(negedge clk); s_init = 0; acc = 32'd2048;
      @(negedge clk); k_fin = 0;
      @(negedge clk);
      @(negedge clk); #1 chk("mid_owe", owe, 1); chk("mid_oa", oa, 1);
      rst = 1'b0;
      #1;
      chk("arst_owe", owe, 0);
      chk("arst_oa", oa, 0);
      chk("arst_odata", odata, 0);
      chk("arst_outr", outr, 0);
      chk("arst_busy", out_busy, 0);
      chk("arst_ba", ba, 0);
      @(negedge clk) rst = 1'b1;
      k_fin = 1; acc = 32'd4096;
      @(negedge clk) k_fin = 0;
      repeat (4) @(negedge clk);
      #1 chk("arst_release_writes", wr_cnt, base + 1);
      chk("arst_release_outr", outr, 0);

      chk("scoreboard_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
